gf_mul_iter: RTL and testbench

Multi-lane iterative GF(2^8) multiplier. Multiplies LANES data bytes by one shared byte multiplier, using shift-and-add with xtime reduction per cycle.
Successor to the single-cycle registered xtime stage: it handles an arbitrary multiplier and adds a handshake.

---
 rtl/gf_mul_iter_pkg.sv | 18 +
 rtl/gf_mul_iter_if.sv | 26 ++
 rtl/gf_mul_iter_lane.sv | 36 +++
 rtl/gf_mul_iter.sv | 82 ++++++++
 tb/tb_gf_mul_iter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/gf_mul_iter_pkg.sv
// Shared GF(2^8) definitions for the iterative multiplier: AES reduction byte,
// controller state encoding and the xtime (multiply-by-x) helper.
package aes_gf_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Multiply by x modulo x^8 + poly: shift left, fold the dropped bit back in.
  function automatic logic [7:0] xtime(input logic [7:0] x, input logic [7:0] poly);
    return {x[6:0], 1'b0} ^ (x[7] ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/gf_mul_iter_if.sv
// Operand/result bundle for gf_mul_iter; the master side feeds operands and
// drains products, the slave side is the multiplier.
interface gf_mul_iter_if #(
  parameter int LANES = 4
) ();
  // Both channels are valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; the source holds payload while valid && !ready.
  logic                 in_valid;
  logic                 in_ready;
  logic [8*LANES-1:0]   a;
  logic [7:0]           b;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/gf_mul_iter_lane.sv
// One byte lane of the shift-and-add GF(2^8) multiplier: holds the running
// multiplicand (doubled each step) and the XOR accumulator.
module gf_mul_lane
  import aes_gf_pkg::*;
#(
  parameter logic [7:0] POLY = AES_POLY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_step,
  input  logic       i_add,
  input  logic [7:0] i_a,
  output logic [7:0] o_acc_nxt
);

  logic [7:0] r_a;
  logic [7:0] r_acc;

  // Accumulator value after the current step; the top samples it on the last step.
  assign o_acc_nxt = r_acc ^ (i_add ? r_a : 8'h00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= 8'h00;
      r_acc <= 8'h00;
    end else if (i_load) begin
      r_a   <= i_a;
      r_acc <= 8'h00;
    end else if (i_step) begin
      r_acc <= o_acc_nxt;
      r_a   <= xtime(r_a, POLY);
    end
  end

endmodule

// File: rtl/gf_mul_iter.sv
// Multi-lane iterative GF(2^8) multiplier: LANES bytes times one shared byte.
// Define GF_MUL_EARLY_DONE_EN to leave RUN as soon as the remaining multiplier is zero.
module gf_mul_iter
  import aes_gf_pkg::*;
#(
  parameter int         LANES = 4,
  parameter logic [7:0] POLY  = AES_POLY
) (
  input  logic   clk,
  input  logic   rst,
  gf_mul_iter_if.slave bus,
  output state_e o_dbg_state
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [7:0]         r_b;
  logic [2:0]         r_count;
  logic [8*LANES-1:0] r_product;
  logic [8*LANES-1:0] w_acc_nxt;
  logic               w_load;
  logic               w_step;
  logic               w_last;

  assign w_load = (r_state == IDLE) && bus.in_valid;
  assign w_step = (r_state == RUN);

`ifdef GF_MUL_EARLY_DONE_EN
  // Remaining multiplier bits all zero after this shift: nothing left to add.
  assign w_last = (r_b[7:1] == 7'd0);
`else
  assign w_last = (r_count == 3'd7);
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gf_mul_lane #(.POLY(POLY)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load),
      .i_step    (w_step),
      .i_add     (r_b[0]),
      .i_a       (bus.a[8*i +: 8]),
      .o_acc_nxt (w_acc_nxt[8*i +: 8])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)        w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_b       <= 8'h00;
      r_count   <= 3'd0;
      r_product <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_b     <= bus.b;
        r_count <= 3'd0;
      end else if (w_step) begin
        r_b     <= r_b >> 1;
        r_count <= r_count + 3'd1;
        if (w_last) r_product <= w_acc_nxt;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.product   = r_product;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_gf_mul_iter.sv
// Bench for gf_mul_iter (LANES=4): fixed vectors, backpressure, mid-run reset,
// back-to-back stream and random operands against a polynomial-arithmetic model.
module tb_gf_mul_iter;
  import aes_gf_pkg::*;

  localparam int LANES = 4;
  localparam int W     = 8 * LANES;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_e dbg_state;
  int     n_pass  = 0;
  int     n_total = 0;
  logic [W-1:0] exp_q[$];
  int           lat_q[$];

  gf_mul_iter_if #(.LANES(LANES)) bus ();

  gf_mul_iter #(.LANES(LANES), .POLY(AES_POLY)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Reference: carry-less polynomial product, then reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_byte(input logic [7:0] x, input logic [7:0] y);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (y[i]) p ^= (15'(x) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= (15'h11B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] av, input logic [7:0] bv);
    logic [W-1:0] r;
    for (int l = 0; l < LANES; l++) r[8*l +: 8] = gf_byte(av[8*l +: 8], bv);
    return r;
  endfunction

  function automatic int exp_lat(input logic [7:0] bv);
`ifdef GF_MUL_EARLY_DONE_EN
    for (int i = 7; i >= 0; i--) if (bv[i]) return i + 1;
    return 1;
`else
    return (bv == bv) ? 8 : 8;
`endif
  endfunction

  function automatic void chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endfunction

  task automatic run_op(input logic [W-1:0] av, input logic [7:0] bv, input logic [W-1:0] exp_p,
                        input int hold, input string tag);
    int lat;
    logic [W-1:0] held;
    @(negedge clk);
    chk({tag, " in_ready idle"}, W'(bus.in_ready), W'(1));
    bus.in_valid  = 1'b1;
    bus.a         = av;
    bus.b         = bv;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = 8'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, W'(lat), W'(exp_lat(bv)));
    chk({tag, " product"}, bus.product, exp_p);
    held = bus.product;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = W'($urandom);
      bus.b        = 8'($urandom);
      @(posedge clk);
      #1;
      chk({tag, " held product"}, bus.product, held);
      chk({tag, " held out_valid"}, W'(bus.out_valid), W'(1));
      chk({tag, " held in_ready"}, W'(bus.in_ready), W'(0));
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, " release out_valid"}, W'(bus.out_valid), W'(0));
    chk({tag, " release in_ready"}, W'(bus.in_ready), W'(1));
    chk({tag, " release busy"}, W'(bus.busy), W'(0));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [7:0]   b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [W-1:0] ra;
    logic [7:0]   rb;
    vecs[0] = '{32'h00_01_80_57, 8'h02, 32'h00_02_1B_AE};
    vecs[1] = '{32'h00_00_00_57, 8'h83, 32'h00_00_00_C1};
    vecs[2] = '{32'h00_00_00_57, 8'h13, 32'h00_00_00_FE};
    vecs[3] = '{32'h00_00_00_D4, 8'h02, 32'h00_00_00_B3};
    vecs[4] = '{32'h00_00_00_D4, 8'h03, 32'h00_00_00_67};
    vecs[5] = '{32'h00_00_00_D4, 8'h0E, 32'h00_00_00_34};
    vecs[6] = '{32'hD4_D4_D4_D4, 8'h00, 32'h00_00_00_00};
    vecs[7] = '{32'hDE_AD_BE_D4, 8'h01, 32'hDE_AD_BE_D4};
    vecs[8] = '{32'h00_00_00_00, 8'hFF, 32'h00_00_00_00};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", W'(bus.in_ready), W'(1));
    chk("reset out_valid", W'(bus.out_valid), W'(0));
    chk("reset product", bus.product, '0);
    chk("reset busy", W'(bus.busy), W'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, 0, $sformatf("vec%0d", i));

    run_op(32'h12_34_56_57, 8'h83, model(32'h12_34_56_57, 8'h83), 5, "backpressure");

    // Reset lands on the edge of the third RUN step.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 32'h00_00_00_57;
    bus.b        = 8'h83;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrun reset in_ready", W'(bus.in_ready), W'(1));
    chk("midrun reset out_valid", W'(bus.out_valid), W'(0));
    chk("midrun reset product", bus.product, '0);
    chk("midrun reset busy", W'(bus.busy), W'(0));
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h00_00_00_57, 8'h83, 32'h00_00_00_C1, 0, "after reset");

    // Back-to-back stream with in_valid held high.
    begin
      logic [W-1:0] sa[4];
      logic [7:0]   sb[4];
      for (int i = 0; i < 4; i++) begin
        sa[i] = W'($urandom);
        sb[i] = (i == 1) ? 8'h02 : 8'($urandom);
        exp_q.push_back(model(sa[i], sb[i]));
        lat_q.push_back(exp_lat(sb[i]));
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      fork
        begin : drv
          for (int i = 0; i < 4; i++) begin
            int guard;
            logic rdy;
            bus.in_valid = 1'b1;
            bus.a        = sa[i];
            bus.b        = sb[i];
            guard = 0;
            rdy   = bus.in_ready;
            while (!rdy && guard < 40) begin
              @(negedge clk);
              rdy = bus.in_ready;
              guard++;
            end
            if (!rdy) $display("FAIL stream accept %0d: in_ready stayed 0, expected 1", i);
            @(posedge clk);
            @(negedge clk);
          end
          bus.in_valid = 1'b0;
        end
        begin : mon
          int cyc, last, got, lat;
          logic [W-1:0] e;
          cyc = 0; last = -1; got = 0;
          while (got < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid && bus.out_ready) begin
              e   = exp_q.pop_front();
              lat = lat_q.pop_front();
              chk($sformatf("stream product %0d", got), bus.product, e);
              if (last >= 0) chk($sformatf("stream gap %0d", got), W'(cyc - last), W'(lat + 2));
              last = cyc;
              got++;
            end
          end
          chk("stream result count", W'(got), W'(4));
        end
      join
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      exp_q.delete();
      lat_q.delete();
    end

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = (i % 4 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      run_op(ra, rb, model(ra, rb), $urandom_range(0, 3), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
